// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//   Two requesters share one 64-bit add/sub datapath. A round-robin grant
//   picks one request while IDLE. The operands are registered and the
//   result is computed in EXEC. The result is then held in RESP until the
//   consumer accepts it. One op completes every 3 cycles at best.
// Ports
//   clk, rst_n               : clock, async active-low reset
//   req_valid/req_ready[1:0] : per-requester handshake (ready only in IDLE)
//   req_a0/b0, req_a1/b1     : signed 64-bit operands per requester
//   req_sub[1:0]             : per-requester op, 0 = a+b, 1 = a-b
//   rsp_valid/rsp_ready      : result handshake
//   rsp_id                   : requester that owns the result
//   rsp_sum, rsp_cout/ovf/zf/sf : result and flags
//   busy                     : FSM not IDLE
//   op_count                 : completed response handshakes (wraps)

module addsub64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        sub_i,
  output logic [63:0] sum_o,
  output logic        cout_o,
  output logic        ovf_o
);
  logic [63:0] b_x;
  logic [62:0] lo;
  logic        c63;
  logic        top;

  // Split at bit 63 so the carry into the MSB is visible for overflow.
  always_comb begin
    b_x           = sub_i ? ~b_i : b_i;
    {c63, lo}     = {1'b0, a_i[62:0]} + {1'b0, b_x[62:0]} + {63'b0, sub_i};
    {cout_o, top} = {1'b0, a_i[63]} + {1'b0, b_x[63]} + {1'b0, c63};
    sum_o         = {top, lo};
    ovf_o         = c63 ^ cout_o;
  end
endmodule

module addsub_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a0,
  input  logic [63:0] req_b0,
  input  logic [63:0] req_a1,
  input  logic [63:0] req_b1,
  input  logic [1:0]  req_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf,
  output logic        rsp_zf,
  output logic        rsp_sf,
  output logic        busy,
  output logic [31:0] op_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  // The last grant resets to the other requester, so RR_INIT wins the first tie.
  localparam logic LAST_RST = (RR_INIT == 0) ? 1'b1 : 1'b0;

  logic [1:0]  state_q, state_d;
  logic        last_q;
  logic        gnt;
  logic        accept;
  logic [63:0] a_q, b_q;
  logic        sub_q, id_q;
  logic [63:0] sum_q;
  logic        cout_q, ovf_q, zf_q, sf_q;
  logic [31:0] cnt_q;
  logic [63:0] dp_sum;
  logic        dp_cout, dp_ovf;

  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b11) gnt = ~last_q;
    else if (req_valid[1] && !req_valid[0]) gnt = 1'b1;
  end

  // The ready output is gated by rst_n so it stays low while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && state_q == IDLE && req_valid != 2'b00) req_ready[gnt] = 1'b1;
  end

  assign accept = (state_q == IDLE) && (req_valid != 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  addsub64 u_dp (
    .a_i    (a_q),
    .b_i    (b_q),
    .sub_i  (sub_q),
    .sum_o  (dp_sum),
    .cout_o (dp_cout),
    .ovf_o  (dp_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= gnt;
        id_q   <= gnt;
        a_q    <= gnt ? req_a1 : req_a0;
        b_q    <= gnt ? req_b1 : req_b0;
        sub_q  <= req_sub[gnt];
      end
      if (state_q == EXEC) begin
        sum_q  <= dp_sum;
        cout_q <= dp_cout;
        ovf_q  <= dp_ovf;
        zf_q   <= (dp_sum == 64'd0);
        sf_q   <= dp_sum[63];
      end
      if (state_q == RESP && rsp_ready) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_zf    = zf_q;
  assign rsp_sf    = sf_q;
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_sub = 2'b00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [63:0] rsp_sum;
  logic        rsp_cout, rsp_ovf, rsp_zf, rsp_sf, busy;
  logic [31:0] op_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.RR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sub(req_sub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .busy(busy), .op_count(op_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the signed/unsigned meaning of the op.
  // Returns {sum, cout, ovf, zf, sf}.
  function automatic logic [67:0] calc(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [64:0] wide;
    logic [63:0] r;
    logic c, v;
    if (!s) begin
      wide = {1'b0, a} + {1'b0, b};
      r = wide[63:0];
      c = wide[64];
      v = (a[63] == b[63]) && (r[63] != a[63]);
    end else begin
      r = a - b;
      c = (a >= b);                       // no borrow
      v = (a[63] != b[63]) && (r[63] != a[63]);
    end
    return {r, c, v, (r == 64'd0), r[63]};
  endfunction

  // Behavioural model: 0 idle, 1 computing, 2 result presented.
  int          m_ph;
  logic        m_last;
  logic        m_id;
  logic [67:0] m_res;
  logic [31:0] m_cnt;

  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[0] ? 1'b0 : 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_last <= 1'b1; m_id <= 1'b0; m_res <= '0; m_cnt <= '0;
    end else begin
      case (m_ph)
        0: if (req_valid != 2'b00) begin
             m_id   <= pick(req_valid, m_last);
             m_last <= pick(req_valid, m_last);
             m_res  <= pick(req_valid, m_last) ? calc(req_a1, req_b1, req_sub[1])
                                               : calc(req_a0, req_b0, req_sub[0]);
             m_ph   <= 1;
           end
        1: m_ph <= 2;
        default: if (rsp_ready) begin m_ph <= 0; m_cnt <= m_cnt + 32'd1; end
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [1:0] er;
    er = 2'b00;
    if (rst_n && m_ph == 0 && req_valid != 2'b00) er[pick(req_valid, m_last)] = 1'b1;
    check("req_ready", {62'b0, req_ready}, {62'b0, er});
    check("rsp_valid", {63'b0, rsp_valid}, {63'b0, (m_ph == 2)});
    check("busy", {63'b0, busy}, {63'b0, (m_ph != 0)});
    check("op_count", {32'b0, op_count}, {32'b0, m_cnt});
    if (m_ph == 2) begin
      check("rsp_id", {63'b0, rsp_id}, {63'b0, m_id});
      check("rsp_sum", rsp_sum, m_res[67:4]);
      check("rsp_flags", {60'b0, rsp_cout, rsp_ovf, rsp_zf, rsp_sf}, {60'b0, m_res[3:0]});
    end
  end

  // Single-requester op; checks latency and the literal result.
  task automatic do_op(input logic id, input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic [63:0] esum, input logic [3:0] eflags);
    int n;
    logic [31:0] c0;
    @(posedge clk); #1;
    c0 = op_count;
    rsp_ready = 1'b1;
    if (id) begin req_a1 = a; req_b1 = b; end else begin req_a0 = a; req_b0 = b; end
    req_sub[id] = s;
    req_valid = id ? 2'b10 : 2'b01;
    @(posedge clk); #1;                 // accepted at this edge
    req_valid = 2'b00;
    n = 1;
    while (!rsp_valid && n < 8) begin @(posedge clk); #1; n++; end
    check("latency", 64'(n), 64'd2);
    check("op_sum", rsp_sum, esum);
    check("op_flags", {60'b0, rsp_cout, rsp_ovf, rsp_zf, rsp_sf}, {60'b0, eflags});
    check("op_id", {63'b0, rsp_id}, {63'b0, id});
    @(posedge clk); #1;
    check("op_count_inc", {32'b0, op_count}, {32'b0, c0 + 32'd1});
  endtask

  initial begin
    int order[$];
    int n;
    logic [63:0] hs;
    logic [3:0]  hf;
    // Pin the reference function with hand-computed values.
    check("model_add", calc(64'd5, 64'd7, 1'b0), {64'd12, 4'b0000});
    check("model_sub0", calc(64'd3, 64'd3, 1'b1), {64'd0, 4'b1010});
    check("model_ovf", calc(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0), {64'h8000_0000_0000_0000, 4'b0101});

    #12;
    check("rst_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_ready", {62'b0, req_ready}, 64'd0);
    check("rst_sum", rsp_sum, 64'd0);
    check("rst_flags", {59'b0, rsp_id, rsp_cout, rsp_ovf, rsp_zf, rsp_sf}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention order with both requesters held valid.
    req_valid = 2'b11;
    n = 0;
    while (order.size() < 4 && n < 40) begin
      @(negedge clk);
      if (rsp_valid) order.push_back(int'(rsp_id));
      n++;
    end
    check("order_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < order.size(); i++) check("order", 64'(order[i]), 64'(i % 2));
    #1 req_valid = 2'b00;
    repeat (3) @(posedge clk);

    do_op(1'b0, 64'd5, 64'd7, 1'b0, 64'd12, 4'b0000);
    do_op(1'b1, 64'd3, 64'd3, 1'b1, 64'd0, 4'b1010);
    do_op(1'b1, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001);
    do_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b0101);
    do_op(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 4'b1110);

    // Backpressure for 10 cycles in RESP.
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_a0 = 64'd100; req_b0 = 64'd1; req_sub = 2'b01; req_valid = 2'b01;
    @(posedge clk); #1 req_valid = 2'b11;
    n = 0;
    while (!rsp_valid && n < 8) begin @(posedge clk); #1; n++; end
    check("bp_reach_resp", {63'b0, rsp_valid}, 64'd1);
    hs = rsp_sum; hf = {rsp_cout, rsp_ovf, rsp_zf, rsp_sf};
    check("bp_sum", hs, 64'd99);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {rsp_sum, rsp_valid, busy, req_ready}, {hs, 1'b1, 1'b1, 2'b00});
      check("bp_flags", {60'b0, rsp_cout, rsp_ovf, rsp_zf, rsp_sf}, {60'b0, hf});
    end
    n = int'(op_count);
    rsp_ready = 1'b1; req_valid = 2'b00;
    @(posedge clk); #1;
    check("bp_done", {32'b0, op_count}, 64'(n + 1));
    repeat (2) @(posedge clk);

    // Reset during EXEC discards the op.
    #1 req_valid = 2'b01;
    @(posedge clk); #1 req_valid = 2'b00;
    rst_n = 1'b0; #2;
    check("rst_exec", {busy, rsp_valid, req_ready, op_count}, 36'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    check("rst_exec_idle", {63'b0, busy}, 64'd0);
    req_valid = 2'b11;
    @(posedge clk); #1 req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 8) begin @(posedge clk); #1; n++; end
    check("rst_rr_winner", {63'b0, rsp_id}, 64'd0);

    // Random traffic checked by the per-cycle compare.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom);
      req_sub   = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_a0 = ($urandom_range(0, 3) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : {$urandom, $urandom};
      req_a1 = ($urandom_range(0, 3) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      req_b1 = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
